mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port RAM arbiter for the KANADE32 core. It shares the one synchronous RAM port between instruction fetch and the memory-access stage, which replaces the fixed fetch/data address mux. Each cycle it grants one requester, drives the RAM word address and write enable, and routes the one-cycle-late read data back to the owner. It also provides a fetch-stall signal to the pipeline controller and a bounded-starvation guarantee for fetch.

## Interface
Parameters:
- STARVE_MAX, 4, consecutive cycles fetch may lose to data while requesting; 0 = fetch never forced (pure data priority)

Ports:
- clk  in  1  core clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  32  fetch byte address; bits [1:0] ignored
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  fetch data valid this cycle
- if_rdata  out  32  fetch data
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address; must be word aligned
- d_wdata  in  32  store data
- d_gnt  out  1  data accepted this cycle (combinational)
- d_rvalid  out  1  load data (or load error) valid this cycle
- d_rdata  out  32  load data
- d_err  out  1  misaligned access response, same cycle as response slot
- stall_fetch  out  1  if_req & ~if_gnt
- ram_address  out  30  RAM word address
- ram_data  out  32  RAM write data
- ram_wren  out  1  RAM write enable
- ram_q  in  32  RAM read data, registered inside RAM (valid cycle after address)

## Operation
- Each cycle, pick at most one winner.
  - Only one req: that requester wins.
  - Both req: data wins, unless STARVE_MAX≠0 and starve_cnt==STARVE_MAX, in which case fetch wins.
- starve_cnt (width clog2(STARVE_MAX+1), min 1):
  - increments when if_req=1 and data wins;
  - clears when fetch wins or if_req=0;
  - saturates at STARVE_MAX.
- Winner gets gnt=1 this cycle. The requester drops or changes its request after a granted edge.
- Fetch grant: ram_address=if_addr[31:2], ram_wren=0.
- Data grant, aligned:
  - ram_address=d_addr[31:2], ram_data=d_wdata, ram_wren=d_we.
- Data grant, misaligned (d_addr[1:0]≠0):
  - d_gnt=1 and ram_wren=0 (no RAM write);
  - the response slot carries d_err=1;
  - a load also gets d_rvalid=1 with d_rdata=0.
- No grant: ram_address=0, ram_wren=0, ram_data=0.
- Response owner register resp_own ∈ {NONE, IF, D_LD, D_ST, D_ERR_LD, D_ERR_ST}, loaded every cycle from that cycle's grant.
- Response cycle by owner:
  - IF: if_rvalid=1, if_rdata=ram_q.
  - D_LD: d_rvalid=1, d_rdata=ram_q.
  - D_ST: no rvalid; the store is complete at the grant edge.
  - D_ERR_*: d_err=1 (plus d_rvalid for a load).
- Between responses, if_rdata and d_rdata hold the last value delivered on that channel (held registers updated on rvalid).

## Timing
- Grant and RAM address: combinational, same cycle as request (zero-wait grant).
- Read latency: data at cycle N+1 for a grant at cycle N.
- Throughput: one access per cycle, back-to-back, any mix.
- Store: written at the grant edge. A load of the same word granted next cycle returns the new data.
- Reset values:
  - if_gnt/d_gnt follow inputs (combinational);
  - if_rvalid=0, d_rvalid=0, d_err=0;
  - if_rdata=0, d_rdata=0;
  - resp_own=NONE, starve_cnt=0.
- Reset asserted mid-operation: the pending response is dropped and no rvalid follows deassertion.
- A request arriving the cycle after a grant to the same requester is a new access.

## Structure
- Shared package kanade32_mem_pkg holds:
  - resp_own enum;
  - WORD_ADDR_W=30;
  - helper constant for the byte-offset width (2).
- Single module, no sub-module: arbitration plus starve counter plus response register.
- The top-level replaces the ram_addr_src mux with this block. CONTROL consumes stall_fetch.

## Test plan
- Fetch only: if_req=1 with if_addr=0x0, 0x4, 0x8 on consecutive cycles → if_gnt each cycle; if_rvalid on the next cycle with RAM words 0, 1, 2.
- Contention, STARVE_MAX=4: both req held for 8 cycles → d wins cycles 0–3, if wins cycle 4, d wins 5–7; stall_fetch=1 except cycle 4.
- Store then load:
  - d store 0xDEADBEEF to 0x100 at cycle N, load 0x100 at N+1;
  - expect d_rdata=0xDEADBEEF with d_rvalid at N+2.
- Misaligned access:
  - load from 0x102 → d_gnt=1, next cycle d_rvalid=1, d_err=1, d_rdata=0, ram_wren never 1;
  - store to 0x103 → d_err=1, no rvalid, RAM unchanged.
- Reset mid-read: grant a fetch at N, pull reset_n low before edge N+1 → if_rvalid=0, if_rdata=0, starve_cnt=0 after release.
- STARVE_MAX=0: both req for 10 cycles → data granted all 10 cycles, if_gnt=0 throughout.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the KANADE32 single-port RAM arbiter: response
// owner encoding and address geometry.
package kanade32_mem_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int BYTE_OFF_W  = 2;

  typedef enum logic [2:0] {
    OWN_NONE     = 3'd0,
    OWN_IF       = 3'd1,
    OWN_D_LD     = 3'd2,
    OWN_D_ST     = 3'd3,
    OWN_D_ERR_LD = 3'd4,
    OWN_D_ERR_ST = 3'd5
  } resp_own_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and RAM port seen by the arbiter.
interface mem_arbiter_if;
  import kanade32_mem_pkg::*;

  // Handshake: a requester raises req with its payload and holds both
  // until it sees gnt in the same cycle; the access is taken at that
  // rising edge. Read data arrives one cycle later with rvalid (and d_err
  // for a misaligned data access); stores produce no rvalid.
  logic                   if_req;
  logic [31:0]            if_addr;
  logic                   if_gnt;
  logic                   if_rvalid;
  logic [31:0]            if_rdata;

  logic                   d_req;
  logic                   d_we;
  logic [31:0]            d_addr;
  logic [31:0]            d_wdata;
  logic                   d_gnt;
  logic                   d_rvalid;
  logic [31:0]            d_rdata;
  logic                   d_err;

  logic                   stall_fetch;

  logic [WORD_ADDR_W-1:0] ram_address;
  logic [31:0]            ram_data;
  logic                   ram_wren;
  logic [31:0]            ram_q;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_q,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
    output stall_fetch, ram_address, ram_data, ram_wren
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_q,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
    input  stall_fetch, ram_address, ram_data, ram_wren
  );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one synchronous RAM port between instruction fetch and data
// access: zero-wait grant, one-cycle read return, bounded fetch starvation.
module mem_arbiter
  import kanade32_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  mem_arbiter_if.slave bus,
  output resp_own_e   o_dbg_resp_own,
  output logic [7:0]  o_dbg_starve_cnt
);

  localparam int              SW         = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0]          r_starve_cnt;
  resp_own_e              r_resp_own;
  logic [31:0]            r_if_hold;
  logic [31:0]            r_d_hold;

  resp_own_e              w_own_nxt;
  logic                   w_force_if;
  logic                   w_if_win;
  logic                   w_d_win;
  logic                   w_misalign;
  logic [WORD_ADDR_W-1:0] w_ram_address;
  logic [31:0]            w_ram_data;
  logic                   w_ram_wren;
  logic                   w_if_rvalid;
  logic                   w_d_rvalid;
  logic                   w_d_err;
  logic [31:0]            w_if_rdata;
  logic [31:0]            w_d_rdata;
  logic                   w_unused_if_off;

  // Fetch only overrides data priority once it has lost STARVE_MAX times in a row.
  assign w_force_if = (STARVE_MAX != 0) && (r_starve_cnt == STARVE_LIM);
  assign w_if_win   = bus.if_req & (~bus.d_req | w_force_if);
  assign w_d_win    = bus.d_req & ~w_if_win;
  assign w_misalign = (bus.d_addr[BYTE_OFF_W-1:0] != '0);

  assign w_unused_if_off = ^bus.if_addr[BYTE_OFF_W-1:0];

  always_comb begin
    w_ram_address = '0;
    w_ram_data    = '0;
    w_ram_wren    = 1'b0;
    w_own_nxt     = OWN_NONE;
    if (w_if_win) begin
      w_ram_address = bus.if_addr[31:BYTE_OFF_W];
      w_own_nxt     = OWN_IF;
    end else if (w_d_win) begin
      if (w_misalign) begin
        // Misaligned access never reaches the RAM; only the error slot is booked.
        w_own_nxt = bus.d_we ? OWN_D_ERR_ST : OWN_D_ERR_LD;
      end else begin
        w_ram_address = bus.d_addr[31:BYTE_OFF_W];
        w_ram_data    = bus.d_wdata;
        w_ram_wren    = bus.d_we;
        w_own_nxt     = bus.d_we ? OWN_D_ST : OWN_D_LD;
      end
    end
  end

  assign w_if_rvalid = (r_resp_own == OWN_IF);
  assign w_d_rvalid  = (r_resp_own == OWN_D_LD) || (r_resp_own == OWN_D_ERR_LD);
  assign w_d_err     = (r_resp_own == OWN_D_ERR_LD) || (r_resp_own == OWN_D_ERR_ST);

  always_comb begin
    w_if_rdata = r_if_hold;
    w_d_rdata  = r_d_hold;
    if (w_if_rvalid) begin
      w_if_rdata = bus.ram_q;
    end
    if (r_resp_own == OWN_D_LD) begin
      w_d_rdata = bus.ram_q;
    end else if (r_resp_own == OWN_D_ERR_LD) begin
      w_d_rdata = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_resp_own   <= OWN_NONE;
      r_starve_cnt <= '0;
      r_if_hold    <= '0;
      r_d_hold     <= '0;
    end else begin
      r_resp_own <= w_own_nxt;
      if (w_if_rvalid) begin
        r_if_hold <= w_if_rdata;
      end
      if (w_d_rvalid) begin
        r_d_hold <= w_d_rdata;
      end
      if (!bus.if_req || w_if_win) begin
        r_starve_cnt <= '0;
      end else if (w_d_win && (r_starve_cnt != STARVE_LIM)) begin
        r_starve_cnt <= r_starve_cnt + SW'(1);
      end
    end
  end

  assign bus.if_gnt      = w_if_win;
  assign bus.d_gnt       = w_d_win;
  assign bus.stall_fetch = bus.if_req & ~w_if_win;
  assign bus.ram_address = w_ram_address;
  assign bus.ram_data    = w_ram_data;
  assign bus.ram_wren    = w_ram_wren;
  assign bus.if_rvalid   = w_if_rvalid;
  assign bus.if_rdata    = w_if_rdata;
  assign bus.d_rvalid    = w_d_rvalid;
  assign bus.d_rdata     = w_d_rdata;
  assign bus.d_err       = w_d_err;

  assign o_dbg_resp_own   = r_resp_own;
  assign o_dbg_starve_cnt = 8'(r_starve_cnt);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table for single-cycle behaviour
// plus sequences for contention, STARVE_MAX=0 and reset during a read.
module tb_mem_arbiter;
  import kanade32_mem_pkg::*;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic       clk;
  logic       reset_n;
  int         checks;
  int         failures;
  resp_own_e  own_a, own_b;
  logic [7:0] starve_a, starve_b;
  logic [31:0] exp_q[$];

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];

  mem_arbiter_if bus_a ();
  mem_arbiter_if bus_b ();

  mem_arbiter #(.STARVE_MAX(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a.slave),
    .o_dbg_resp_own(own_a), .o_dbg_starve_cnt(starve_a)
  );

  mem_arbiter #(.STARVE_MAX(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b.slave),
    .o_dbg_resp_own(own_b), .o_dbg_starve_cnt(starve_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous RAM models, word i preset to value i
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'(i);
      mem_b[i] = 32'(i);
    end
  end

  always @(posedge clk) begin
    if (bus_a.ram_wren) mem_a[bus_a.ram_address[7:0]] <= bus_a.ram_data;
    bus_a.ram_q <= mem_a[bus_a.ram_address[7:0]];
    if (bus_b.ram_wren) mem_b[bus_b.ram_address[7:0]] <= bus_b.ram_data;
    bus_b.ram_q <= mem_b[bus_b.ram_address[7:0]];
  end

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        e_if_gnt;
    logic        e_d_gnt;
    logic        e_stall;
    logic        chk_addr;
    logic [29:0] e_addr;
    logic        e_wren;
    logic [31:0] e_wdata;
    logic        e_if_rvalid;
    logic [31:0] e_if_rdata;
    logic        e_d_rvalid;
    logic [31:0] e_d_rdata;
    logic        e_d_err;
  } vec_t;

  vec_t vtab [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_a(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dw, input logic [31:0] da, input logic [31:0] dd);
    bus_a.if_req  = ir;
    bus_a.if_addr = ia;
    bus_a.d_req   = dr;
    bus_a.d_we    = dw;
    bus_a.d_addr  = da;
    bus_a.d_wdata = dd;
  endtask

  task automatic drive_b(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dw, input logic [31:0] da, input logic [31:0] dd);
    bus_b.if_req  = ir;
    bus_b.if_addr = ia;
    bus_b.d_req   = dr;
    bus_b.d_we    = dw;
    bus_b.d_addr  = da;
    bus_b.d_wdata = dd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_d;
    logic prev_d;
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    drive_a(F, 0, F, F, 0, 0);
    drive_b(F, 0, F, F, 0, 0);

    //            if_req if_addr      d_req d_we d_addr       d_wdata       | if_gnt d_gnt stall chk addr   wren wdata         if_rv if_rdata     d_rv d_rdata      d_err
    vtab[0]  = '{F, 32'h0,   F, F, 32'h0,   32'h0,        F, F, F, T, 30'h0,  F, 32'h0,        F, 32'h0,  F, 32'h0,        F};
    vtab[1]  = '{T, 32'h0,   F, F, 32'h0,   32'h0,        T, F, F, T, 30'h0,  F, 32'h0,        F, 32'h0,  F, 32'h0,        F};
    vtab[2]  = '{T, 32'h4,   F, F, 32'h0,   32'h0,        T, F, F, T, 30'h1,  F, 32'h0,        T, 32'h0,  F, 32'h0,        F};
    vtab[3]  = '{T, 32'h8,   F, F, 32'h0,   32'h0,        T, F, F, T, 30'h2,  F, 32'h0,        T, 32'h1,  F, 32'h0,        F};
    vtab[4]  = '{F, 32'h0,   F, F, 32'h0,   32'h0,        F, F, F, T, 30'h0,  F, 32'h0,        T, 32'h2,  F, 32'h0,        F};
    vtab[5]  = '{F, 32'h0,   F, F, 32'h0,   32'h0,        F, F, F, T, 30'h0,  F, 32'h0,        F, 32'h2,  F, 32'h0,        F};
    vtab[6]  = '{F, 32'h0,   T, T, 32'h100, 32'hDEADBEEF, F, T, F, T, 30'h40, T, 32'hDEADBEEF, F, 32'h2,  F, 32'h0,        F};
    vtab[7]  = '{F, 32'h0,   T, F, 32'h100, 32'h0,        F, T, F, T, 30'h40, F, 32'h0,        F, 32'h2,  F, 32'h0,        F};
    vtab[8]  = '{F, 32'h0,   F, F, 32'h0,   32'h0,        F, F, F, T, 30'h0,  F, 32'h0,        F, 32'h2,  T, 32'hDEADBEEF, F};
    vtab[9]  = '{F, 32'h0,   T, F, 32'h102, 32'h0,        F, T, F, F, 30'h0,  F, 32'h0,        F, 32'h2,  F, 32'hDEADBEEF, F};
    vtab[10] = '{F, 32'h0,   T, T, 32'h103, 32'h12345678, F, T, F, F, 30'h0,  F, 32'h0,        F, 32'h2,  T, 32'h0,        T};
    vtab[11] = '{F, 32'h0,   T, F, 32'h100, 32'h0,        F, T, F, T, 30'h40, F, 32'h0,        F, 32'h2,  F, 32'h0,        T};
    vtab[12] = '{F, 32'h0,   F, F, 32'h0,   32'h0,        F, F, F, T, 30'h0,  F, 32'h0,        F, 32'h2,  T, 32'hDEADBEEF, F};
    vtab[13] = '{T, 32'h10,  T, F, 32'hC,   32'h0,        F, T, T, T, 30'h3,  F, 32'h0,        F, 32'h2,  F, 32'hDEADBEEF, F};
    vtab[14] = '{F, 32'h0,   F, F, 32'h0,   32'h0,        F, F, F, T, 30'h0,  F, 32'h0,        F, 32'h2,  T, 32'h3,        F};
    vtab[15] = '{T, 32'h104, F, F, 32'h0,   32'h0,        T, F, F, T, 30'h41, F, 32'h0,        F, 32'h2,  F, 32'h3,        F};
    vtab[16] = '{F, 32'h0,   T, F, 32'h100, 32'h0,        F, T, F, T, 30'h40, F, 32'h0,        T, 32'h41, F, 32'h3,        F};
    vtab[17] = '{F, 32'h0,   F, F, 32'h0,   32'h0,        F, F, F, T, 30'h0,  F, 32'h0,        F, 32'h41, T, 32'hDEADBEEF, F};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_if_rvalid", 32'(bus_a.if_rvalid), 0);
    chk("rst_a_d_rvalid",  32'(bus_a.d_rvalid), 0);
    chk("rst_a_d_err",     32'(bus_a.d_err), 0);
    chk("rst_a_if_rdata",  bus_a.if_rdata, 0);
    chk("rst_a_d_rdata",   bus_a.d_rdata, 0);
    chk("rst_a_own",       32'(own_a), 32'(OWN_NONE));
    chk("rst_a_starve",    32'(starve_a), 0);
    chk("rst_b_if_rvalid", 32'(bus_b.if_rvalid), 0);
    chk("rst_b_d_rvalid",  32'(bus_b.d_rvalid), 0);
    reset_n = 1'b1;
    next_cycle();

    // table-driven vectors on the STARVE_MAX=4 instance
    for (int i = 0; i < 18; i++) begin
      drive_a(vtab[i].if_req, vtab[i].if_addr, vtab[i].d_req, vtab[i].d_we,
              vtab[i].d_addr, vtab[i].d_wdata);
      @(negedge clk);
      chk($sformatf("v%0d_if_gnt", i),    32'(bus_a.if_gnt),      32'(vtab[i].e_if_gnt));
      chk($sformatf("v%0d_d_gnt", i),     32'(bus_a.d_gnt),       32'(vtab[i].e_d_gnt));
      chk($sformatf("v%0d_stall", i),     32'(bus_a.stall_fetch), 32'(vtab[i].e_stall));
      chk($sformatf("v%0d_wren", i),      32'(bus_a.ram_wren),    32'(vtab[i].e_wren));
      if (vtab[i].chk_addr)
        chk($sformatf("v%0d_ram_addr", i), 32'(bus_a.ram_address), 32'(vtab[i].e_addr));
      if (vtab[i].e_wren)
        chk($sformatf("v%0d_ram_data", i), bus_a.ram_data, vtab[i].e_wdata);
      chk($sformatf("v%0d_if_rvalid", i), 32'(bus_a.if_rvalid),   32'(vtab[i].e_if_rvalid));
      chk($sformatf("v%0d_if_rdata", i),  bus_a.if_rdata,         vtab[i].e_if_rdata);
      chk($sformatf("v%0d_d_rvalid", i),  32'(bus_a.d_rvalid),    32'(vtab[i].e_d_rvalid));
      chk($sformatf("v%0d_d_rdata", i),   bus_a.d_rdata,          vtab[i].e_d_rdata);
      chk($sformatf("v%0d_d_err", i),     32'(bus_a.d_err),       32'(vtab[i].e_d_err));
      next_cycle();
    end

    // contention, STARVE_MAX=4: data wins 4 times, then fetch once
    exp_q = '{1, 1, 1, 1, 0, 1, 1, 1};
    prev_d = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive_a(T, 32'h20, T, F, 32'h24, 32'h0);
      exp_d = exp_q.pop_front() != 0;
      @(negedge clk);
      chk($sformatf("cont%0d_d_gnt", k),    32'(bus_a.d_gnt),       32'(exp_d));
      chk($sformatf("cont%0d_if_gnt", k),   32'(bus_a.if_gnt),      32'(!exp_d));
      chk($sformatf("cont%0d_stall", k),    32'(bus_a.stall_fetch), 32'(exp_d));
      chk($sformatf("cont%0d_if_rvalid", k), 32'(bus_a.if_rvalid),  32'(k == 5));
      chk($sformatf("cont%0d_d_rvalid", k), 32'(bus_a.d_rvalid),    32'(prev_d));
      if (k == 5) chk("cont5_if_rdata", bus_a.if_rdata, 32'h8);
      if (prev_d) chk($sformatf("cont%0d_d_rdata", k), bus_a.d_rdata, 32'h9);
      prev_d = exp_d;
      next_cycle();
    end
    drive_a(F, 0, F, F, 0, 0);
    @(negedge clk);
    chk("cont_tail_d_rvalid", 32'(bus_a.d_rvalid), 1);
    chk("cont_tail_d_rdata",  bus_a.d_rdata, 32'h9);
    next_cycle();

    // STARVE_MAX=0: data always wins
    for (int k = 0; k < 10; k++) begin
      drive_b(T, 32'h40, T, F, 32'h44, 32'h0);
      @(negedge clk);
      chk($sformatf("nost%0d_d_gnt", k),  32'(bus_b.d_gnt), 1);
      chk($sformatf("nost%0d_if_gnt", k), 32'(bus_b.if_gnt), 0);
      chk($sformatf("nost%0d_stall", k),  32'(bus_b.stall_fetch), 1);
      next_cycle();
    end
    drive_b(F, 0, F, F, 0, 0);

    // reset during an outstanding fetch read
    drive_a(T, 32'h4, T, F, 32'h24, 32'h0);
    @(negedge clk);
    chk("rr_pre_d_gnt", 32'(bus_a.d_gnt), 1);
    next_cycle();
    drive_a(T, 32'h4, F, F, 32'h0, 32'h0);
    @(negedge clk);
    chk("rr_if_gnt",     32'(bus_a.if_gnt), 1);
    chk("rr_starve_pre", 32'(starve_a), 1);
    chk("rr_if_rdata_pre", bus_a.if_rdata, 32'h8);
    #1;
    reset_n = 1'b0;
    drive_a(F, 0, F, F, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rr_in_if_rvalid", 32'(bus_a.if_rvalid), 0);
    chk("rr_in_if_rdata",  bus_a.if_rdata, 0);
    chk("rr_in_starve",    32'(starve_a), 0);
    chk("rr_in_own",       32'(own_a), 32'(OWN_NONE));
    reset_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rr_post%0d_if_rvalid", k), 32'(bus_a.if_rvalid), 0);
      chk($sformatf("rr_post%0d_if_rdata", k),  bus_a.if_rdata, 0);
      chk($sformatf("rr_post%0d_starve", k),    32'(starve_a), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
